// File: rtl/led_rgb_pkg.sv
// Shared types and LED encodings for the RGB LED arbiter.
// LED values are active-low pin patterns ({B,G,R}, 0 = lit).
package led_rgb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_SHOW
  } state_t;

  localparam logic [2:0] LED_OFF = 3'b111;
  localparam logic [2:0] LED_R   = 3'b110;
  localparam logic [2:0] LED_G   = 3'b101;
  localparam logic [2:0] LED_B   = 3'b011;

  // Idle rotation order R -> G -> B -> R; anything else (OFF) starts at R.
  function automatic logic [2:0] rot_next(input logic [2:0] cur);
    case (cur)
      LED_R:   rot_next = LED_G;
      LED_G:   rot_next = LED_B;
      default: rot_next = LED_R;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks.
// clr restarts the count so the next tick lands exactly TICK_DIV cycles later.
module led_tick_gen #(
  parameter int TICK_DIV = 20_000_000
) (
  input  logic sysclk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_reg;

  assign tick = (cnt_reg == CW'(TICK_DIV - 1));

  always_ff @(posedge sysclk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/led_rgb_arb.sv
// Round-robin arbiter sharing one active-low RGB LED among NREQ requesters.
// Optional idle colour rotation enabled by defining LED_RGB_ARB_IDLE_ROTATE_EN.
module led_rgb_arb
  import led_rgb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int TICK_DIV = 20_000_000,
  parameter int DUR_W    = 8
) (
  input  logic                      sysclk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [3*NREQ-1:0]         color,
  input  logic [DUR_W*NREQ-1:0]     dur,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic [2:0]                leds
);

  localparam int OW_W = $clog2(NREQ);

  logic [2:0]       color_arr [NREQ];
  logic [DUR_W-1:0] dur_arr   [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign color_arr[gi] = color[3*gi +: 3];
      assign dur_arr[gi]   = dur[DUR_W*gi +: DUR_W];
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [OW_W-1:0]   owner_reg, owner_next;
  logic [DUR_W-1:0]  dur_reg, dur_next;
  logic [DUR_W-1:0]  tick_cnt_reg, tick_cnt_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [NREQ-1:0]   done_reg, done_next;
  logic [2:0]        leds_reg, leds_next;
  logic              tick_clr;
  logic              tick;
  logic              pick_valid;
  logic [OW_W-1:0]   pick_idx;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .sysclk (sysclk),
    .rst    (rst),
    .clr    (tick_clr),
    .tick   (tick)
  );

  // Search starts just past the last owner so it gets the lowest priority.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!pick_valid && req[(int'(owner_reg) + k) % NREQ]) begin
        pick_valid = 1'b1;
        pick_idx   = OW_W'((int'(owner_reg) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    dur_next      = dur_reg;
    tick_cnt_next = tick_cnt_reg;
    leds_next     = leds_reg;
    gnt_next      = '0;
    done_next     = '0;
    tick_clr      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next    = ST_SHOW;
          owner_next    = pick_idx;
          gnt_next      = NREQ'(1) << pick_idx;
          dur_next      = (dur_arr[pick_idx] == '0) ? DUR_W'(1) : dur_arr[pick_idx];
          tick_cnt_next = '0;
          leds_next     = ~color_arr[pick_idx];
          tick_clr      = 1'b1;
        end else begin
`ifdef LED_RGB_ARB_IDLE_ROTATE_EN
          if (tick) begin
            leds_next = rot_next(leds_reg);
          end
`else
          leds_next = LED_OFF;
`endif
        end
      end
      ST_SHOW: begin
        if (tick) begin
          if ((tick_cnt_reg + DUR_W'(1)) == dur_reg) begin
            state_next = ST_IDLE;
            done_next  = NREQ'(1) << owner_reg;
            leds_next  = LED_OFF;
            tick_clr   = 1'b1;
          end else begin
            tick_cnt_next = tick_cnt_reg + DUR_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        leds_next  = LED_OFF;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= OW_W'(NREQ - 1);
      dur_reg      <= '0;
      tick_cnt_reg <= '0;
      gnt_reg      <= '0;
      done_reg     <= '0;
      leds_reg     <= LED_OFF;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      dur_reg      <= dur_next;
      tick_cnt_reg <= tick_cnt_next;
      gnt_reg      <= gnt_next;
      done_reg     <= done_next;
      leds_reg     <= leds_next;
    end
  end

  assign gnt   = gnt_reg;
  assign done  = done_reg;
  assign busy  = (state_reg == ST_SHOW);
  assign owner = owner_reg;
  assign leds  = leds_reg;

endmodule

// File: tb/tb_led_rgb_arb.sv
// Directed scoreboard bench for led_rgb_arb (NREQ=2, TICK_DIV=4, DUR_W=8).
// Idle-rotation expectations follow LED_RGB_ARB_IDLE_ROTATE_EN when defined.
module tb_led_rgb_arb;

  localparam int NREQ     = 2;
  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 8;

  logic                  sysclk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [3*NREQ-1:0]     color;
  logic [DUR_W*NREQ-1:0] dur;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [0:0]            owner;
  logic [2:0]            leds;

  led_rgb_arb #(.NREQ(NREQ), .TICK_DIV(TICK_DIV), .DUR_W(DUR_W)) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .req    (req),
    .color  (color),
    .dur    (dur),
    .gnt    (gnt),
    .done   (done),
    .busy   (busy),
    .owner  (owner),
    .leds   (leds)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    bit         is_done;
    int         idx;
    int         lit;
    logic [2:0] leds;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_gnt_cyc = 0;
  int   last_done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_gnt(input int idx, input logic [2:0] lv);
    exp_t e;
    e.is_done = 1'b0; e.idx = idx; e.lit = 0; e.leds = lv;
    sb_q.push_back(e);
  endtask

  task automatic push_done(input int idx, input int lit);
    exp_t e;
    e.is_done = 1'b1; e.idx = idx; e.lit = lit; e.leds = 3'b111;
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for the next gnt/done pulse and compares it with the queue head.
  task automatic next_event(input string tag);
    exp_t e;
    int   n;
    int   obs_idx;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while ((gnt | done) == '0 && n < 200);
    check({tag, " evt_seen"}, 32'((gnt | done) != '0), 32'd1);
    if ((gnt | done) == '0) return;
    check({tag, " sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    obs_idx = 0;
    for (int i = 0; i < NREQ; i++) if (gnt[i] || done[i]) obs_idx = i;
    check({tag, " kind"}, 32'(done != '0), 32'(e.is_done));
    check({tag, " onehot"}, 32'($onehot(gnt | done)), 32'd1);
    check({tag, " idx"}, 32'(obs_idx), 32'(e.idx));
    check({tag, " leds"}, 32'(leds), 32'(e.leds));
    check({tag, " busy"}, 32'(busy), 32'(!e.is_done));
    check({tag, " owner"}, 32'(owner), 32'(e.idx));
    if (e.is_done) begin
      check({tag, " lit_cycles"}, 32'(cyc - last_gnt_cyc), 32'(e.lit));
      last_done_cyc = cyc;
    end else begin
      last_gnt_cyc = cyc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int seen;
    logic [2:0] rot_exp [5];
`ifdef LED_RGB_ARB_IDLE_ROTATE_EN
    rot_exp = '{3'b111, 3'b110, 3'b101, 3'b011, 3'b110};
`else
    rot_exp = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
`endif

    // Reset hold and release
    rst = 1'b1; req = '0; color = '0; dur = '0;
    repeat (3) @(negedge sysclk);
    check("rst leds", 32'(leds), 32'h7);
    check("rst gnt", 32'(gnt), 32'h0);
    check("rst done", 32'(done), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst owner", 32'(owner), 32'h1);
    rst = 1'b0;
    repeat (2) @(negedge sysclk);
    check("post_rst leds", 32'(leds), 32'h7);
    check("post_rst gnt", 32'(gnt), 32'h0);
    check("post_rst busy", 32'(busy), 32'h0);

    // Single grant, red, 3 ticks
    color[2:0] = 3'b001; dur[7:0] = 8'd3; req = 2'b01; t0 = cyc;
    push_gnt(0, 3'b110); push_done(0, 12);
    next_event("t2 gnt");
    check("t2 latency", 32'(cyc - t0), 32'd1);
    req = '0;
    next_event("t2 done");

    // Both requesting continuously: rotation 1,0,1,0 with one idle cycle between
    color[5:3] = 3'b010; dur[15:8] = 8'd2; dur[7:0] = 8'd1; req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        push_gnt(1, 3'b101); push_done(1, 8);
      end else begin
        push_gnt(0, 3'b110); push_done(0, 4);
      end
    end
    for (int i = 0; i < 4; i++) begin
      next_event($sformatf("t3 gnt%0d", i));
      if (i > 0) check($sformatf("t3 gap%0d", i), 32'(cyc - last_done_cyc), 32'd1);
      if (i == 3) req = '0;
      next_event($sformatf("t3 done%0d", i));
    end

    // dur=0 behaves as one tick
    color[2:0] = 3'b001; dur[7:0] = 8'd0; req = 2'b01;
    push_gnt(0, 3'b110); push_done(0, 4);
    next_event("t4a gnt");
    req = '0;
    next_event("t4a done");

    // Inputs changed mid-dwell are ignored
    color[2:0] = 3'b100; dur[7:0] = 8'd2; req = 2'b01;
    push_gnt(0, 3'b011); push_done(0, 8);
    next_event("t4b gnt");
    req = '0; color[2:0] = 3'b111; dur[7:0] = 8'd5;
    repeat (2) @(negedge sysclk);
    check("t4b mid leds", 32'(leds), 32'h3);
    next_event("t4b done");

    // Reset mid-dwell aborts with no done
    color[2:0] = 3'b001; dur[7:0] = 8'd3; req = 2'b01;
    push_gnt(0, 3'b110);
    next_event("t5 gnt");
    req = '0;
    repeat (3) @(negedge sysclk);
    rst = 1'b1;
    @(negedge sysclk);
    check("t5 rst leds", 32'(leds), 32'h7);
    check("t5 rst busy", 32'(busy), 32'h0);
    check("t5 rst done", 32'(done), 32'h0);
    check("t5 rst owner", 32'(owner), 32'h1);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge sysclk);
      if (done != '0) seen++;
    end
    check("t5 no_done", 32'(seen), 32'd0);
    check("t5 sb_empty", 32'(sb_q.size()), 32'd0);
    color[2:0] = 3'b010; dur[7:0] = 8'd1; req = 2'b01;
    push_gnt(0, 3'b101); push_done(0, 4);
    next_event("t5b gnt");
    req = '0;
    next_event("t5b done");

    // Idle LED pattern after done, then a grant mid-rotation
    for (int k = 1; k <= 16; k++) begin
      @(negedge sysclk);
      if (k == 3)  check("t6 idle k3",  32'(leds), 32'(rot_exp[0]));
      if (k == 4)  check("t6 idle k4",  32'(leds), 32'(rot_exp[1]));
      if (k == 8)  check("t6 idle k8",  32'(leds), 32'(rot_exp[2]));
      if (k == 12) check("t6 idle k12", 32'(leds), 32'(rot_exp[3]));
      if (k == 16) check("t6 idle k16", 32'(leds), 32'(rot_exp[4]));
    end
    repeat (2) @(negedge sysclk);
    color[5:3] = 3'b100; dur[15:8] = 8'd1; req = 2'b10; t0 = cyc;
    push_gnt(1, 3'b011); push_done(1, 4);
    next_event("t6 gnt");
    check("t6 latency", 32'(cyc - t0), 32'd1);
    req = '0;
    next_event("t6 done");

    check("final sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
